// File: rtl/lc3_pkg.sv
// Shared encodings for the LC-3 control unit and the datapath mux layer:
// FSM state names, opcode values, mux/ALU select codes and the control word.
package lc3_pkg;

    typedef enum logic [4:0] {
        S_HALTED,
        S_18, S_33, S_35, S_32,
        S_01, S_05, S_09,
        S_00, S_22,
        S_12,
        S_04, S_21,
        S_06, S_25, S_27,
        S_07, S_23, S_16,
        S_P1, S_P2
    } state_t;

    // IR[15:12] values decoded in S32
    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    // PC input select
    localparam logic [1:0] PCMUX_PC1   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    // Second address-adder operand
    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    // ALU function
    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    // Every control output of the unit, in one bundle
    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_ce;
        logic       mem_ub;
        logic       mem_lb;
        logic       mem_oe;
        logic       mem_we;
    } ctrl_t;

    // Quiescent control word: nothing loaded, nothing gated, SRAM deselected
    function automatic ctrl_t idle_ctrl();
        ctrl_t c;
        c        = '0;
        c.mem_ce = 1'b1;
        c.mem_ub = 1'b1;
        c.mem_lb = 1'b1;
        c.mem_oe = 1'b1;
        c.mem_we = 1'b1;
        return c;
    endfunction

    // States that hold for MEM_WAIT cycles while the SRAM access completes
    function automatic logic is_mem_state(input state_t s);
        return (s == S_33) || (s == S_25) || (s == S_16);
    endfunction

endpackage

// File: rtl/lc3_mem_wait_ctr.sv
// Dwell counter for the memory states: counts cycles spent in the current
// memory state and flags the last one so the FSM can move on.
module lc3_mem_wait_ctr
    import lc3_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    output logic done
);

    localparam logic [3:0] LAST = 4'(MEM_WAIT - 1);

    logic [3:0] cnt;

    assign done = active && (cnt == LAST);

    // Count while in a memory state; restart at zero on exit so the next entry begins fresh
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt <= '0;
        end else if (!active || done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/lc3_control_unit.sv
// LC-3 control unit: Moore FSM for fetch/decode/execute of ADD, AND, NOT,
// BR, JMP, JSR, LDR, STR and PAUSE. Produces only control strobes; the
// datapath lives elsewhere.
module lc3_control_unit
    import lc3_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    logic   mem_done;

    lc3_mem_wait_ctr #(
        .MEM_WAIT (MEM_WAIT)
    ) u_wait (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .active (is_mem_state(state)),
        .done   (mem_done)
    );

    // State register; reset drops straight to HALTED, which also releases Mem_WE mid-write
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_HALTED;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            S_HALTED: if (Run) state_next = S_18;
            S_18:     state_next = S_33;
            S_33:     if (mem_done) state_next = S_35;
            S_35:     state_next = S_32;
            S_32: begin
                case (Opcode)
                    OP_ADD:   state_next = S_01;
                    OP_AND:   state_next = S_05;
                    OP_NOT:   state_next = S_09;
                    OP_BR:    state_next = S_00;
                    OP_JMP:   state_next = S_12;
                    // Both IR_11 forms take the PC-relative subroutine path
                    OP_JSR:   state_next = IR_11 ? S_04 : S_04;
                    OP_LDR:   state_next = S_06;
                    OP_STR:   state_next = S_07;
                    OP_PAUSE: state_next = S_P1;
                    default:  state_next = S_18;
                endcase
            end
            S_01, S_05, S_09: state_next = S_18;
            S_00:     state_next = BEN ? S_22 : S_18;
            S_22:     state_next = S_18;
            S_12:     state_next = S_18;
            S_04:     state_next = S_21;
            S_21:     state_next = S_18;
            S_06:     state_next = S_25;
            S_25:     if (mem_done) state_next = S_27;
            S_27:     state_next = S_18;
            S_07:     state_next = S_23;
            S_23:     state_next = S_16;
            S_16:     if (mem_done) state_next = S_18;
            S_P1:     if (Continue) state_next = S_P2;
            S_P2:     if (!Continue) state_next = S_18;
            default:  state_next = S_HALTED;
        endcase
    end

    // Control word decoded from the current state; idle values unless a state overrides
    always_comb begin
        ctrl = idle_ctrl();
        unique case (state)
            S_18: begin
                ctrl.gate_pc = 1'b1;
                ctrl.ld_mar  = 1'b1;
                ctrl.pcmux   = PCMUX_PC1;
                ctrl.ld_pc   = 1'b1;
            end
            S_33, S_25: begin
                ctrl.mem_ce = 1'b0;
                ctrl.mem_oe = 1'b0;
                ctrl.mem_ub = 1'b0;
                ctrl.mem_lb = 1'b0;
                ctrl.ld_mdr = 1'b1;
            end
            S_35: begin
                ctrl.gate_mdr = 1'b1;
                ctrl.ld_ir    = 1'b1;
            end
            S_32: ctrl.ld_ben = 1'b1;
            S_01, S_05, S_09: begin
                ctrl.sr1mux   = 1'b1;
                ctrl.sr2mux   = IR_5;
                ctrl.gate_alu = 1'b1;
                ctrl.drmux    = 1'b0;
                ctrl.ld_reg   = 1'b1;
                ctrl.ld_cc    = 1'b1;
                ctrl.aluk     = (state == S_01) ? ALUK_ADD :
                                (state == S_05) ? ALUK_AND : ALUK_NOT;
            end
            S_22: begin
                ctrl.addr1mux = 1'b0;
                ctrl.addr2mux = ADDR2_OFF9;
                ctrl.pcmux    = PCMUX_ADDER;
                ctrl.ld_pc    = 1'b1;
            end
            S_12: begin
                ctrl.sr1mux   = 1'b1;
                ctrl.addr1mux = 1'b1;
                ctrl.addr2mux = ADDR2_ZERO;
                ctrl.pcmux    = PCMUX_ADDER;
                ctrl.ld_pc    = 1'b1;
            end
            S_04: begin
                ctrl.gate_pc = 1'b1;
                ctrl.drmux   = 1'b1;
                ctrl.ld_reg  = 1'b1;
            end
            S_21: begin
                ctrl.addr1mux = 1'b0;
                ctrl.addr2mux = ADDR2_OFF11;
                ctrl.pcmux    = PCMUX_ADDER;
                ctrl.ld_pc    = 1'b1;
            end
            S_06, S_07: begin
                ctrl.sr1mux      = 1'b1;
                ctrl.addr1mux    = 1'b1;
                ctrl.addr2mux    = ADDR2_OFF6;
                ctrl.gate_marmux = 1'b1;
                ctrl.ld_mar      = 1'b1;
            end
            S_27: begin
                ctrl.gate_mdr = 1'b1;
                ctrl.drmux    = 1'b0;
                ctrl.ld_reg   = 1'b1;
                ctrl.ld_cc    = 1'b1;
            end
            S_23: begin
                ctrl.sr1mux   = 1'b0;
                ctrl.aluk     = ALUK_PASSA;
                ctrl.gate_alu = 1'b1;
                ctrl.ld_mdr   = 1'b1;
            end
            S_16: begin
                ctrl.mem_ce = 1'b0;
                ctrl.mem_we = 1'b0;
                ctrl.mem_ub = 1'b0;
                ctrl.mem_lb = 1'b0;
                ctrl.mem_oe = 1'b1;
            end
            S_P1: ctrl.ld_led = 1'b1;
            default: ;
        endcase
    end

    assign LD_MAR     = ctrl.ld_mar;
    assign LD_MDR     = ctrl.ld_mdr;
    assign LD_IR      = ctrl.ld_ir;
    assign LD_BEN     = ctrl.ld_ben;
    assign LD_CC      = ctrl.ld_cc;
    assign LD_REG     = ctrl.ld_reg;
    assign LD_PC      = ctrl.ld_pc;
    assign LD_LED     = ctrl.ld_led;
    assign GatePC     = ctrl.gate_pc;
    assign GateMDR    = ctrl.gate_mdr;
    assign GateALU    = ctrl.gate_alu;
    assign GateMARMUX = ctrl.gate_marmux;
    assign PCMUX      = ctrl.pcmux;
    assign DRMUX      = ctrl.drmux;
    assign SR1MUX     = ctrl.sr1mux;
    assign SR2MUX     = ctrl.sr2mux;
    assign ADDR1MUX   = ctrl.addr1mux;
    assign ADDR2MUX   = ctrl.addr2mux;
    assign ALUK       = ctrl.aluk;
    assign Mem_CE     = ctrl.mem_ce;
    assign Mem_UB     = ctrl.mem_ub;
    assign Mem_LB     = ctrl.mem_lb;
    assign Mem_OE     = ctrl.mem_oe;
    assign Mem_WE     = ctrl.mem_we;

endmodule

// File: tb/tb_lc3_control_unit.sv
// Directed bench for lc3_control_unit. The main instance (MEM_WAIT=2) is
// stepped cycle by cycle against a scoreboard of expected control words; a
// second instance (MEM_WAIT=3) is used to measure memory-state dwell times.
module tb_lc3_control_unit;

    logic       Clk;
    logic       Reset_n;
    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       IR_11;
    logic       BEN;
    logic       Run3;
    logic [3:0] Opcode3;

    // Control word bit layout, MSB first:
    // LD_MAR LD_MDR LD_IR LD_BEN LD_CC LD_REG LD_PC LD_LED GatePC GateMDR GateALU GateMARMUX
    // PCMUX[1:0] DRMUX SR1MUX SR2MUX ADDR1MUX ADDR2MUX[1:0] ALUK[1:0] CE UB LB OE WE
    wire [26:0] o;
    wire [26:0] o3;

    int checks = 0;
    int errors = 0;

    logic [26:0] exp_q[$];
    string       tag_q[$];

    typedef enum {
        H, F18, F33, F35, F32, E01, E05, E09, E00, E22, E12,
        E04, E21, E06, E07, E25, E27, E23, E16, EP1, EP2
    } st_e;

    lc3_control_unit #(.MEM_WAIT(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(o[26]), .LD_MDR(o[25]), .LD_IR(o[24]), .LD_BEN(o[23]),
        .LD_CC(o[22]), .LD_REG(o[21]), .LD_PC(o[20]), .LD_LED(o[19]),
        .GatePC(o[18]), .GateMDR(o[17]), .GateALU(o[16]), .GateMARMUX(o[15]),
        .PCMUX(o[14:13]), .DRMUX(o[12]), .SR1MUX(o[11]), .SR2MUX(o[10]),
        .ADDR1MUX(o[9]), .ADDR2MUX(o[8:7]), .ALUK(o[6:5]),
        .Mem_CE(o[4]), .Mem_UB(o[3]), .Mem_LB(o[2]), .Mem_OE(o[1]), .Mem_WE(o[0])
    );

    lc3_control_unit #(.MEM_WAIT(3)) dut3 (
        .Clk(Clk), .Reset_n(Reset_n), .Run(Run3), .Continue(Continue),
        .Opcode(Opcode3), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(o3[26]), .LD_MDR(o3[25]), .LD_IR(o3[24]), .LD_BEN(o3[23]),
        .LD_CC(o3[22]), .LD_REG(o3[21]), .LD_PC(o3[20]), .LD_LED(o3[19]),
        .GatePC(o3[18]), .GateMDR(o3[17]), .GateALU(o3[16]), .GateMARMUX(o3[15]),
        .PCMUX(o3[14:13]), .DRMUX(o3[12]), .SR1MUX(o3[11]), .SR2MUX(o3[10]),
        .ADDR1MUX(o3[9]), .ADDR2MUX(o3[8:7]), .ALUK(o3[6:5]),
        .Mem_CE(o3[4]), .Mem_UB(o3[3]), .Mem_LB(o3[2]), .Mem_OE(o3[1]), .Mem_WE(o3[0])
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expected control word for each state, written out from the state table
    function automatic logic [26:0] exp_out(input st_e s, input logic ir5);
        logic ld_mar = 0, ld_mdr = 0, ld_ir = 0, ld_ben = 0, ld_cc = 0, ld_reg = 0;
        logic ld_pc = 0, ld_led = 0, g_pc = 0, g_mdr = 0, g_alu = 0, g_marmux = 0;
        logic [1:0] pcmux = 2'b00, addr2mux = 2'b00, aluk = 2'b00;
        logic drmux = 0, sr1mux = 0, sr2mux = 0, addr1mux = 0;
        logic ce = 1, ub = 1, lb = 1, oe = 1, we = 1;
        case (s)
            F18: begin g_pc = 1; ld_mar = 1; ld_pc = 1; end
            F33, E25: begin ce = 0; oe = 0; ub = 0; lb = 0; ld_mdr = 1; end
            F35: begin g_mdr = 1; ld_ir = 1; end
            F32: ld_ben = 1;
            E01: begin sr1mux = 1; sr2mux = ir5; g_alu = 1; ld_reg = 1; ld_cc = 1; end
            E05: begin sr1mux = 1; sr2mux = ir5; g_alu = 1; ld_reg = 1; ld_cc = 1; aluk = 2'b01; end
            E09: begin sr1mux = 1; sr2mux = ir5; g_alu = 1; ld_reg = 1; ld_cc = 1; aluk = 2'b10; end
            E22: begin addr2mux = 2'b10; pcmux = 2'b10; ld_pc = 1; end
            E12: begin sr1mux = 1; addr1mux = 1; pcmux = 2'b10; ld_pc = 1; end
            E04: begin g_pc = 1; drmux = 1; ld_reg = 1; end
            E21: begin addr2mux = 2'b11; pcmux = 2'b10; ld_pc = 1; end
            E06, E07: begin sr1mux = 1; addr1mux = 1; addr2mux = 2'b01; g_marmux = 1; ld_mar = 1; end
            E27: begin g_mdr = 1; ld_reg = 1; ld_cc = 1; end
            E23: begin aluk = 2'b11; g_alu = 1; ld_mdr = 1; end
            E16: begin ce = 0; we = 0; ub = 0; lb = 0; end
            EP1: ld_led = 1;
            default: ;
        endcase
        return {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                g_pc, g_mdr, g_alu, g_marmux, pcmux, drmux, sr1mux, sr2mux,
                addr1mux, addr2mux, aluk, ce, ub, lb, oe, we};
    endfunction

    // Pop the oldest expectation and compare it with the current outputs
    task automatic compare_head();
        logic [26:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %07h expected %07h", t, o, e);
        end
        checks++;
        assert (($countones(o[18:15]) <= 1) && (o[1] || o[0])) else begin
            errors++;
            $error("FAIL %s_bus_invariant: observed gates %04b oe/we %02b", t, o[18:15], o[1:0]);
        end
    endtask

    // Queue the expected word for the next cycle, clock once, then compare
    task automatic step(input st_e s, input string tag);
        exp_q.push_back(exp_out(s, IR_5));
        tag_q.push_back(tag);
        @(posedge Clk);
        #1;
        compare_head();
    endtask

    // Compare immediately without a clock edge (asynchronous reset checks)
    task automatic check_now(input st_e s, input string tag);
        exp_q.push_back(exp_out(s, IR_5));
        tag_q.push_back(tag);
        compare_head();
    endtask

    // Fetch tail from S18 with MEM_WAIT=2: S33 twice, S35, S32
    task automatic fetch(input string tag);
        step(F33, {tag, "_s33a"});
        step(F33, {tag, "_s33b"});
        step(F35, {tag, "_s35"});
        step(F32, {tag, "_s32"});
    endtask

    // Count cycles of dut3 with a given output bit low over n cycles
    task automatic count_low3(input int bitpos, input int n, output int cnt);
        cnt = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge Clk);
            #1;
            Run3 = 1'b0;
            if (o3[bitpos] == 1'b0) cnt++;
        end
    endtask

    initial begin
        int n;
        Reset_n  = 1'b0;
        Run      = 1'b0;
        Continue = 1'b0;
        Opcode   = 4'b0000;
        IR_5     = 1'b0;
        IR_11    = 1'b1;
        BEN      = 1'b0;
        Run3     = 1'b0;
        Opcode3  = 4'b0000;

        #2 check_now(H, "reset");
        #6 Reset_n = 1'b1;
        step(H, "idle0");
        step(H, "idle1");

        // ADD immediate, Run left high to show it is ignored while running
        Opcode = 4'b0001; IR_5 = 1'b1; Run = 1'b1;
        step(F18, "add_s18");
        Run = 1'b0;
        fetch("add");
        step(E01, "add_s01");
        step(F18, "add_next");

        Opcode = 4'b0101; IR_5 = 1'b0;
        fetch("and");
        step(E05, "and_s05");
        step(F18, "and_next");

        Opcode = 4'b1001;
        fetch("not");
        step(E09, "not_s09");
        step(F18, "not_next");

        Opcode = 4'b0000; BEN = 1'b0;
        fetch("br_nt");
        step(E00, "br_nt_s00");
        step(F18, "br_nt_next");

        BEN = 1'b1;
        fetch("br_t");
        step(E00, "br_t_s00");
        step(E22, "br_t_s22");
        step(F18, "br_t_next");

        Opcode = 4'b1100;
        fetch("jmp");
        step(E12, "jmp_s12");
        step(F18, "jmp_next");

        Opcode = 4'b0100; IR_11 = 1'b0;
        fetch("jsr");
        step(E04, "jsr_s04");
        step(E21, "jsr_s21");
        step(F18, "jsr_next");

        Opcode = 4'b0111;
        fetch("str");
        step(E07, "str_s07");
        step(E23, "str_s23");
        step(E16, "str_s16a");
        step(E16, "str_s16b");
        step(F18, "str_next");

        Opcode = 4'b0110;
        fetch("ldr");
        step(E06, "ldr_s06");
        step(E25, "ldr_s25a");
        step(E25, "ldr_s25b");
        step(E27, "ldr_s27");
        step(F18, "ldr_next");

        // PAUSE: wait for Continue press and release
        Opcode = 4'b1101;
        fetch("pause");
        step(EP1, "pause_p1a");
        step(EP1, "pause_p1b");
        Continue = 1'b1;
        for (int i = 0; i < 10; i++) step(EP2, "pause_p2_held");
        Continue = 1'b0;
        step(F18, "pause_release");

        Opcode = 4'b1111;
        fetch("nop");
        step(F18, "nop_next");

        // Reset asserted in the middle of a write
        Opcode = 4'b0111;
        fetch("str2");
        step(E07, "str2_s07");
        step(E23, "str2_s23");
        step(E16, "str2_s16");
        #2 Reset_n = 1'b0;
        #1 check_now(H, "rst_mid_write");
        #2 Reset_n = 1'b1;
        step(H, "post_rst0");
        step(H, "post_rst1");

        // MEM_WAIT=3 instance: STR dwell then LDR dwell
        Opcode3 = 4'b0111;
        Run3 = 1'b1;
        count_low3(0, 12, n);
        checks++;
        assert (n === 3) else begin
            errors++;
            $error("FAIL mw3_write_cycles: observed %0d expected %0d", n, 3);
        end
        checks++;
        assert (o3 === exp_out(F18, IR_5)) else begin
            errors++;
            $error("FAIL mw3_after_str: observed %07h expected %07h", o3, exp_out(F18, IR_5));
        end
        Opcode3 = 4'b0110;
        count_low3(1, 5, n);
        checks++;
        assert (n === 3) else begin
            errors++;
            $error("FAIL mw3_fetch_read_cycles: observed %0d expected %0d", n, 3);
        end
        count_low3(1, 6, n);
        checks++;
        assert (n === 3) else begin
            errors++;
            $error("FAIL mw3_ldr_read_cycles: observed %0d expected %0d", n, 3);
        end
        checks++;
        assert (o3 === exp_out(F18, IR_5)) else begin
            errors++;
            $error("FAIL mw3_after_ldr: observed %07h expected %07h", o3, exp_out(F18, IR_5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
